// File: rtl/inst_encoder_pkg.sv
// -----------------------------------------------------------------------------
// inst_encoder_pkg
//   Shared definitions for the RV32I instruction encoder.
//   - fmt_e        : instruction format selector (I, S, B, reserved)
//   - OP_*         : the base opcodes the encoder accepts
//   - IMM*_MIN/MAX : signed immediate ranges for the 12-bit (I/S) and
//                    13-bit byte-offset (B) immediates
//   - ERR_CNT_MAX  : saturation point of the error counter
//   - imm_in_range : signed range test used by the packer
// -----------------------------------------------------------------------------
package inst_encoder_pkg;

  typedef enum logic [1:0] {
    FMT_I   = 2'd0,
    FMT_S   = 2'd1,
    FMT_B   = 2'd2,
    FMT_RSV = 2'd3
  } fmt_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // 12-bit signed immediate (I and S formats).
  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;

  // B-format byte offset: 13-bit signed, even values only, so the largest
  // reachable positive offset is 4094 rather than 4095.
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4094;

  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

  // True when the 32-bit two's-complement value lies in [lo, hi].
  function automatic logic imm_in_range(input logic [31:0] value,
                                        input int lo,
                                        input int hi);
    int sval;
    sval = int'($signed(value));
    return (sval >= lo) && (sval <= hi);
  endfunction

endpackage

// File: rtl/inst_encoder_pack.sv
// -----------------------------------------------------------------------------
// inst_pack
//   Purely combinational field packer and checker. Builds the 32-bit
//   instruction word for the selected format and flags any word whose
//   opcode does not belong to the format, whose immediate is out of range,
//   or whose B offset is odd. Flagged words are still packed, with the
//   immediate simply truncated to the bits the format carries.
//
//   Ports
//     fmt     in  2   format select (fmt_e encoding)
//     opcode  in  7   opcode field
//     rd      in  5   destination register
//     rs1     in  5   source register 1
//     rs2     in  5   source register 2
//     funct3  in  3   funct3 field
//     imm     in  32  signed immediate (byte offset for B)
//     inst    out 32  packed instruction word
//     err     out 1   word failed at least one check
// -----------------------------------------------------------------------------
module inst_pack
  import inst_encoder_pkg::*;
(
  input  logic [1:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [31:0] imm,
  output logic [31:0] inst,
  output logic        err
);

  logic op_ok;
  logic range_ok;

  // NOTE: every output of a combinational block gets a default on entry so
  // no path through the case can leave it unassigned and infer a latch.
  always_comb begin
    inst     = '0;
    err      = 1'b0;
    op_ok    = 1'b0;
    range_ok = 1'b0;

    case (fmt_e'(fmt))
      FMT_I: begin
        inst     = {imm[11:0], rs1, funct3, rd, opcode};
        op_ok    = (opcode == OP_IMM) || (opcode == OP_LOAD);
        range_ok = imm_in_range(imm, IMM12_MIN, IMM12_MAX);
        err      = !op_ok || !range_ok;
      end

      FMT_S: begin
        inst     = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        op_ok    = (opcode == OP_STORE);
        range_ok = imm_in_range(imm, IMM12_MIN, IMM12_MAX);
        err      = !op_ok || !range_ok;
      end

      FMT_B: begin
        // imm[0] has no slot: the decoder reconstructs a half-word offset.
        inst     = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        op_ok    = (opcode == OP_BRANCH);
        range_ok = imm_in_range(imm, IMM13_MIN, IMM13_MAX) && !imm[0];
        err      = !op_ok || !range_ok;
      end

      FMT_RSV: begin
        inst = '0;
        err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// -----------------------------------------------------------------------------
// inst_encoder
//   Program-loader stage that turns instruction field tuples into 32-bit
//   RV32I words tagged with an instruction-memory word address and an error
//   flag. A single registered valid/ready slot sits between the command
//   stream and the memory write port; the ready path is combinational so a
//   word can be accepted every cycle while downstream keeps up.
//
//   Parameters
//     ADDR_W     word address width (counter wraps modulo 2^ADDR_W)
//     BASE_ADDR  address loaded on reset and on start
//
//   Ports
//     clk        in  1       clock, rising edge
//     rst_n      in  1       synchronous active-low reset
//     start      in  1       reload address counter, clear err_cnt
//     in_valid   in  1       field inputs valid
//     in_ready   out 1       encoder can accept this cycle
//     fmt        in  2       0=I, 1=S, 2=B, 3=reserved
//     opcode     in  7       opcode field
//     rd         in  5       destination register
//     rs1        in  5       source register 1
//     rs2        in  5       source register 2
//     funct3     in  3       funct3 field
//     imm        in  32      signed immediate (byte offset for B)
//     out_valid  out 1       out_* holds an encoded word
//     out_ready  in  1       downstream accepts
//     out_inst   out 32      encoded instruction
//     out_addr   out ADDR_W  word address of out_inst
//     out_err    out 1       word failed a check
//     err_cnt    out 8       saturating count of accepted words with error
// -----------------------------------------------------------------------------
module inst_encoder
  import inst_encoder_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        fmt,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [7:0]        err_cnt
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  logic [31:0]       pk_inst;
  logic              pk_err;
  logic              accept;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] word_addr;

  inst_pack u_pack (
    .fmt    (fmt),
    .opcode (opcode),
    .rd     (rd),
    .rs1    (rs1),
    .rs2    (rs2),
    .funct3 (funct3),
    .imm    (imm),
    .inst   (pk_inst),
    .err    (pk_err)
  );

  // The slot can take a new word when empty or when its current word
  // leaves this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // A start coinciding with an accept restarts numbering at this word.
  assign word_addr = start ? BASE : addr_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order in the block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_addr  <= '0;
      out_err   <= 1'b0;
      addr_cnt  <= BASE;
      err_cnt   <= '0;
    end else begin
      // Output slot: load on accept, otherwise drain on handshake. Held
      // data stays untouched while stalled, and start never flushes it.
      if (accept) begin
        out_valid <= 1'b1;
        out_inst  <= pk_inst;
        out_addr  <= word_addr;
        out_err   <= pk_err;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // Address counter wraps silently modulo 2^ADDR_W.
      if (accept) begin
        addr_cnt <= word_addr + ADDR_W'(1);
      end else if (start) begin
        addr_cnt <= BASE;
      end

      // Error counter: start clears it, but an error word accepted in the
      // same cycle is still counted.
      if (start) begin
        err_cnt <= {7'd0, accept && pk_err};
      end else if (accept && pk_err && (err_cnt != ERR_CNT_MAX)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;
  import inst_encoder_pkg::*;

  localparam int ADDR_W = 8;
  localparam int BASE   = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, in_valid, out_ready;
  logic [1:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm;

  logic              in_ready, out_valid, out_err;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_addr;
  logic [7:0]        err_cnt;

  // Second instance with a 2-bit address to exercise counter wrap.
  logic        in_ready2, out_valid2, out_err2;
  logic [31:0] out_inst2;
  logic [1:0]  out_addr2;
  logic [7:0]  err_cnt2;

  inst_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr),
    .out_err(out_err), .err_cnt(err_cnt)
  );

  inst_encoder #(.ADDR_W(2), .BASE_ADDR(BASE)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready2),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .imm(imm),
    .out_valid(out_valid2), .out_ready(out_ready), .out_inst(out_inst2), .out_addr(out_addr2),
    .out_err(out_err2), .err_cnt(err_cnt2)
  );

  typedef struct {
    logic [31:0] inst;
    logic [7:0]  addr;
    logic        err;
    logic [1:0]  fmt;
    logic [31:0] imm;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  int model_cnt = BASE;
  int model_err = 0;
  bit bp_en = 1'b0;

  logic [31:0] last_inst;
  logic [7:0]  last_addr;
  logic        last_err;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference encoder straight from the format tables and range rules.
  function automatic exp_t model(input logic [1:0] f, input logic [6:0] op,
                                 input logic [4:0] d, input logic [4:0] s1,
                                 input logic [4:0] s2, input logic [2:0] f3,
                                 input logic [31:0] im);
    exp_t e;
    longint v;
    v = longint'($signed(im));
    e.fmt = f;
    e.imm = im;
    e.addr = '0;
    case (f)
      2'd0: begin
        e.inst = {im[11:0], s1, f3, d, op};
        e.err  = !(op == 7'b0010011 || op == 7'b0000011) || v < -2048 || v > 2047;
      end
      2'd1: begin
        e.inst = {im[11:5], s2, s1, f3, im[4:0], op};
        e.err  = (op != 7'b0100011) || v < -2048 || v > 2047;
      end
      2'd2: begin
        e.inst = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
        e.err  = (op != 7'b1100011) || v < -4096 || v > 4094 || (v % 2 != 0);
      end
      default: begin
        e.inst = 32'h0;
        e.err  = 1'b1;
      end
    endcase
    return e;
  endfunction

  // Immediate generator (decode side) for the round-trip property.
  function automatic logic [31:0] decode_imm(input logic [31:0] w, input logic [1:0] f);
    case (f)
      2'd0:    return {{20{w[31]}}, w[31:20]};
      2'd1:    return {{20{w[31]}}, w[31:25], w[11:7]};
      default: return {{20{w[31]}}, w[31], w[7], w[30:25], w[11:8]};
    endcase
  endfunction

  task automatic send(input logic [1:0] f, input logic [6:0] op, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                      input logic [31:0] im, input bit st);
    exp_t e;
    int n;
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; imm = im;
    in_valid = 1'b1;
    start = st;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: in_ready stuck at 0, required 1");
    end else begin
      e = model(f, op, d, s1, s2, f3, im);
      if (st) begin
        e.addr    = 8'(BASE);
        model_cnt = (BASE + 1) % 256;
        model_err = e.err ? 1 : 0;
      end else begin
        e.addr    = 8'(model_cnt);
        model_cnt = (model_cnt + 1) % 256;
        if (e.err && model_err < 255) model_err++;
      end
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model_cnt = BASE;
    model_err = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || out_valid) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: %0d words outstanding, required 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  // Monitor: compares each delivered word against the scoreboard head and
  // checks that a stalled word does not change.
  exp_t        me;
  bit          held_v = 1'b0;
  logic [31:0] held_inst;
  logic [7:0]  held_addr;
  logic        held_err;

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (out_ready) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_word: got 0x%08h with empty scoreboard", out_inst);
        end else begin
          me = sb.pop_front();
          check("out_inst", out_inst, me.inst);
          check("out_addr", {24'd0, out_addr}, {24'd0, me.addr});
          check("out_err", {31'd0, out_err}, {31'd0, me.err});
          check("wrap_addr", {30'd0, out_addr2}, {30'd0, me.addr[1:0]});
          check("wrap_inst", out_inst2, me.inst);
          check("wrap_ready", {31'd0, in_ready2}, {31'd0, in_ready});
          if (!me.err)
            check("round_trip", decode_imm(out_inst, me.fmt),
                  (me.fmt == 2'd2) ? 32'($signed(me.imm) >>> 1) : me.imm);
          last_inst = out_inst;
          last_addr = out_addr;
          last_err  = out_err;
        end
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          check("hold_inst", out_inst, held_inst);
          check("hold_addr", {24'd0, out_addr}, {24'd0, held_addr});
          check("hold_err", {31'd0, out_err}, {31'd0, held_err});
        end
        held_inst = out_inst;
        held_addr = out_addr;
        held_err  = out_err;
        held_v    = 1'b1;
      end
    end else begin
      held_v = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int bnd[11] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096, 0, -1};

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    fmt = '0; opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; imm = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_addr", {24'd0, out_addr}, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Directed words from the reference examples.
    send(2'd0, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 1'b0);
    drain();
    check("ex_i_inst", last_inst, 32'h00500093);
    check("ex_i_addr", {24'd0, last_addr}, 32'd0);
    send(2'd1, OP_STORE, 5'd0, 5'd2, 5'd3, 3'd2, -32'sd4, 1'b0);
    drain();
    check("ex_s_inst", last_inst, 32'hFE312E23);
    send(2'd2, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, -32'sd8, 1'b0);
    drain();
    check("ex_b_inst", last_inst, 32'hFE208CE3);
    send(2'd2, OP_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3, 1'b0);
    drain();
    check("ex_b_odd_err", {31'd0, last_err}, 32'd1);
    check("ex_b_odd_cnt", {24'd0, err_cnt}, 32'd1);

    // Backpressure: four words while downstream stalls for three cycles.
    start_pulse();
    check("start_clr_cnt", {24'd0, err_cnt}, 32'd0);
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(2'd0, OP_LOAD, 5'(i + 1), 5'd4, 5'd0, 3'd2, 32'(i * 4), 1'b0);
      end
      begin
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
        repeat (3) begin
          @(negedge clk);
          check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_last_addr", {24'd0, last_addr}, 32'd3);

    // Error group: range, opcode mismatch, reserved format.
    start_pulse();
    send(2'd0, OP_IMM, 5'd1, 5'd1, 5'd0, 3'd0, 32'd2048, 1'b0);
    send(2'd1, OP_IMM, 5'd0, 5'd2, 5'd3, 3'd2, 32'd8, 1'b0);
    send(2'd3, OP_IMM, 5'd7, 5'd7, 5'd7, 3'd7, 32'd1, 1'b0);
    drain();
    check("rsv_inst", last_inst, 32'd0);
    check("rsv_err", {31'd0, last_err}, 32'd1);
    check("err_cnt_3", {24'd0, err_cnt}, 32'd3);

    // Start with a simultaneous accept after five words.
    start_pulse();
    for (int i = 0; i < 5; i++)
      send(2'd0, OP_IMM, 5'd2, 5'd3, 5'd0, 3'd0, 32'(i), 1'b0);
    send(2'd1, OP_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 32'd16, 1'b1);
    drain();
    check("start_acc_addr", {24'd0, last_addr}, 32'(BASE));
    send(2'd1, OP_STORE, 5'd0, 5'd1, 5'd2, 3'd2, 32'd20, 1'b0);
    drain();
    check("start_next_addr", {24'd0, last_addr}, 32'(BASE + 1));
    check("start_acc_cnt", {24'd0, err_cnt}, 32'd0);

    // Error counter saturation.
    for (int i = 0; i < 260; i++)
      send(2'd3, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, 1'b0);
    drain();
    check("err_cnt_sat", {24'd0, err_cnt}, 32'd255);

    // Reset mid-stream discards the held word and rewinds the counter.
    out_ready = 1'b0;
    send(2'd0, OP_IMM, 5'd9, 5'd9, 5'd0, 3'd0, 32'd9, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_cnt", {24'd0, err_cnt}, 32'd0);
    rst_n = 1'b1;
    sb.delete();
    model_cnt = BASE;
    model_err = 0;
    out_ready = 1'b1;
    send(2'd0, OP_IMM, 5'd1, 5'd1, 5'd0, 3'd0, 32'd1, 1'b0);
    drain();
    check("mid_rst_addr", {24'd0, last_addr}, 32'(BASE));

    // Randomized traffic with random downstream stalls.
    bp_en = 1'b1;
    fork
      while (bp_en) begin
        @(posedge clk); #1;
        if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
      end
    join_none
    for (int i = 0; i < 300; i++) begin
      logic [1:0]  rf;
      logic [6:0]  rop;
      logic [31:0] rim;
      rf = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) rop = 7'($urandom);
      else case (rf)
        2'd0:    rop = ($urandom_range(0, 1) != 0) ? OP_IMM : OP_LOAD;
        2'd1:    rop = OP_STORE;
        default: rop = OP_BRANCH;
      endcase
      case ($urandom_range(0, 3))
        0:       rim = 32'(int'($urandom_range(0, 4095)) - 2048);
        1:       rim = 32'(bnd[$urandom_range(0, 10)]);
        2:       rim = 32'((int'($urandom_range(0, 4095)) - 2048) * 2);
        default: rim = $urandom;
      endcase
      send(rf, rop, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), rim,
           ($urandom_range(0, 19) == 0));
    end
    bp_en = 1'b0;
    out_ready = 1'b1;
    drain();
    check("rand_err_cnt", {24'd0, err_cnt}, 32'(model_err));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Inverse of the immediate generator: builds 32-bit RV32I instruction words from field inputs (format, opcode, registers, funct3, signed immediate) for the I (addi/lw), S (sw) and B (beq/bge) formats. Adds a word address and an error flag to each instruction. Sits in the program-loader path between the host/testbench command stream and instruction-memory write port. Output is a single registered valid/ready stage. Its B-immediate packing is the exact bit inverse of the decode path.

## Interface
- ADDR_W, 8: instruction-memory word address width.
- BASE_ADDR, 0: address loaded into the address counter on reset and on START.
- CLK  in  1  clock, all state on rising edge.
- RSTn  in  1  synchronous, active-low reset.
- START  in  1  single-cycle pulse; reloads address counter to BASE_ADDR and clears ERR_CNT.
- IN_VALID  in  1  field inputs valid.
- IN_READY  out  1  encoder can accept this cycle.
- FMT  in  2  0=I, 1=S, 2=B, 3=reserved.
- OPCODE  in  7; RD in 5; RS1 in 5; RS2 in 5; FUNCT3 in 3  instruction fields.
- IMM  in  32  signed immediate; B-format value is a byte offset.
- OUT_VALID  out  1  OUT_* holds an encoded word.
- OUT_READY  in  1  downstream accepts.
- OUT_INST  out  32  encoded instruction.
- OUT_ADDR  out  ADDR_W  word address for OUT_INST.
- OUT_ERR  out  1  word failed a check.
- ERR_CNT  out  8  saturating count of accepted words with error.

## Operation
- The encoder accepts a word when IN_VALID && IN_READY. IN_READY = !OUT_VALID || OUT_READY, which is combinational, so full throughput is possible.
- Encoding:
  - I: {IMM[11:0], RS1, FUNCT3, RD, OPCODE}.
  - S: {IMM[11:5], RS2, RS1, FUNCT3, IMM[4:0], OPCODE}.
  - B: {IMM[12], IMM[10:5], RS2, RS1, FUNCT3, IMM[4:1], IMM[11], OPCODE}.
  - FMT=3: OUT_INST=0.
- Error checks. Any failing check sets OUT_ERR=1. The word is still encoded with the immediate truncated.
  - FMT=3 is an error.
  - Opcode/format mismatch: I requires 0010011 or 0000011; S requires 0100011; B requires 1100011.
  - I/S range: IMM must lie in [-2048, 2047].
  - B range: IMM must lie in [-4096, 4094].
  - B alignment: IMM[0] must be 0.
- Round-trip property for error-free words. Decoding OUT_INST through the immediate generator returns:
  - IMM, for I and S.
  - IMM>>>1 (arithmetic shift), for B. The decoder yields the half-word offset.
- Address counter:
  - On accept, OUT_ADDR <= counter and counter <= counter+1.
  - The counter wraps modulo 2^ADDR_W with no flag.
- START:
  - START alone: counter <= BASE_ADDR and ERR_CNT <= 0.
  - START with an accept in the same cycle: the accepted word gets OUT_ADDR=BASE_ADDR, counter <= BASE_ADDR+1, and ERR_CNT <= OUT_ERR of that word.
  - START does not flush the output register.
- ERR_CNT increments on each accept with error and saturates at 255.

## Timing
- Reset values:
  - OUT_VALID=0, OUT_INST=0, OUT_ADDR=0, OUT_ERR=0, ERR_CNT=0.
  - Counter=BASE_ADDR.
  - IN_READY=1 while RSTn=1 after reset.
- Latency: one cycle from accept to OUT_VALID=1.
- OUT_INST, OUT_ADDR and OUT_ERR are stable while OUT_VALID && !OUT_READY.
- OUT_VALID falls only after a handshake with no new accept in the same cycle.
- Back-to-back: with OUT_READY held at 1, one word per cycle.
- Reset mid-stream: RSTn=0 drops OUT_VALID on the next edge and discards the held word; the counter returns to BASE_ADDR.

## Structure
- Shared package holds:
  - Opcode constants: OP_IMM=0010011, OP_LOAD=0000011, OP_STORE=0100011, OP_BRANCH=1100011.
  - FMT encodings: FMT_I, FMT_S, FMT_B, FMT_RSV.
  - Immediate range limits.
- One combinational sub-module, inst_pack, performs field packing and error checks. The top level holds the output register, handshake, address counter and ERR_CNT.

## Test plan
- Reset then I word: FMT=0, OPCODE=0010011, RD=1, RS1=0, FUNCT3=0, IMM=5 -> one cycle later OUT_INST=0x00500093, OUT_ADDR=0, OUT_ERR=0.
- S word: FMT=1, OPCODE=0100011, RS1=2, RS2=3, FUNCT3=2, IMM=-4 -> OUT_INST=0xFE312E23; the immediate generator returns 0xFFFFFFFC.
- B word: FMT=2, OPCODE=1100011, RS1=1, RS2=2, FUNCT3=0, IMM=-8 -> OUT_INST=0xFE208CE3, decode 0xFFFFFFFC. Repeat with IMM=3 -> OUT_ERR=1, ERR_CNT=1.
- Backpressure: 4 words with OUT_READY=0 for 3 cycles -> IN_READY=0 after the first accept, the held word is unchanged, and OUT_ADDR sequence is 0,1,2,3 with none lost.
- Range/opcode errors: I with IMM=2048; S with OPCODE=0010011; FMT=3 -> all give OUT_ERR=1. The FMT=3 word gives OUT_INST=0. ERR_CNT=3.
- START with a simultaneous accept after 5 words -> that word gets OUT_ADDR=BASE_ADDR, the next word gets BASE_ADDR+1, ERR_CNT=0. With ADDR_W=2, the 5th word gets OUT_ADDR=0 (wrap).
